// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared seven-segment definitions. The segment pattern
//               constants are ordered {A,B,C,D,E,F,G} (A in bit 6) and are
//               the single table used by both the display decoder and the
//               capture decoder.
//               Also holds the capture FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    // Capture FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // bus idle, nothing selected
        COUNT = 2'd1,   // pattern changed, waiting for it to settle
        HOLD  = 2'd2    // current pattern already accepted
    } capState_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_decode
// Description : Combinational reverse lookup of a 7-bit segment pattern
//               {A..G} to its hex digit.
// Ports       : pattern  in  [6:0] segment pattern, A in bit 6
//               isLegal  out       pattern is one of the 16 hex glyphs
//               hexValue out [3:0] decoded value (0 when not legal)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       isLegal,
    output logic [3:0] hexValue
);

    always_comb begin
        isLegal  = 1'b1;
        hexValue = 4'h0;
        case (pattern)
            SEG_0:   hexValue = 4'h0;
            SEG_1:   hexValue = 4'h1;
            SEG_2:   hexValue = 4'h2;
            SEG_3:   hexValue = 4'h3;
            SEG_4:   hexValue = 4'h4;
            SEG_5:   hexValue = 4'h5;
            SEG_6:   hexValue = 4'h6;
            SEG_7:   hexValue = 4'h7;
            SEG_8:   hexValue = 4'h8;
            SEG_9:   hexValue = 4'h9;
            SEG_A:   hexValue = 4'hA;
            SEG_B:   hexValue = 4'hB;
            SEG_C:   hexValue = 4'hC;
            SEG_D:   hexValue = 4'hD;
            SEG_E:   hexValue = 4'hE;
            SEG_F:   hexValue = 4'hF;
            default: isLegal  = 1'b0;
        endcase
    end

endmodule : seg_pattern_decode
`default_nettype wire

// File: rtl/seven_seg_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture_decoder
// Description : Monitors a multiplexed seven-segment bus, debounces each
//               (select, segment) pattern, decodes it back to hex and stores
//               the value per digit. Illegal stable patterns raise Error.
// Ports       : Clk, Reset (async, active-high)
//               SegSel[NUM_DIGITS]  one-hot digit select, 0 = bus idle
//               A..G                segment lines, active-high
//               Clear               clears all DigitValid bits
//               Digits[4*NUM_DIGITS] captured values, digit i at [4i+3:4i]
//               DigitValid          per-digit legal-value flag
//               Update / UpdIdx     one-cycle write pulse and digit index
//               Error               one-cycle illegal-pattern pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_DIGITS-1:0]   SegSel,
    input  logic                    A,
    input  logic                    B,
    input  logic                    C,
    input  logic                    D,
    input  logic                    E,
    input  logic                    F,
    input  logic                    G,
    input  logic                    Clear,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic [NUM_DIGITS-1:0]   DigitValid,
    output logic                    Update,
    output logic [IDX_W-1:0]        UpdIdx,
    output logic                    Error
);

    localparam int               SMP_W   = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SMP_W-1:0]        r_s1;
    logic [SMP_W-1:0]        r_prev;
    logic [CNT_W-1:0]        r_cnt;
    capState_t               r_state;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_update;
    logic [IDX_W-1:0]        r_updIdx;
    logic                    r_error;

    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_seg;
    logic                    w_changed;
    logic                    w_active;
    logic                    w_oneHot;
    logic                    w_accept;
    logic [CNT_W-1:0]        w_cntNext;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_legal;
    logic [3:0]              w_value;

    assign w_sel     = r_s1[SMP_W-1:7];
    assign w_seg     = r_s1[6:0];
    assign w_changed = (r_s1 != r_prev);
    assign w_active  = |w_sel;
    assign w_oneHot  = w_active && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);

    // A change counts as the first sample of the new pattern, so the count
    // restarts at 1 rather than 0.
    always_comb begin
        if (w_changed) begin
            w_cntNext = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cntNext = r_cnt;
        end else begin
            w_cntNext = r_cnt + CNT_W'(1);
        end
    end

    // Accept on the edge the count reaches the threshold. The decision uses
    // the next count so that a pattern first sampled at edge k is reported at
    // edge k+STABLE_CYCLES. HOLD blocks re-acceptance of the same window.
    assign w_accept = w_active && (w_changed || (r_state != HOLD))
                      && (w_cntNext == CNT_MAX);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    seg_pattern_decode u_decode (
        .pattern  (w_seg),
        .isLegal  (w_legal),
        .hexValue (w_value)
    );

    // Input sample stage and stability counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1   <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= {SegSel, A, B, C, D, E, F, G};
            r_prev <= r_s1;
            r_cnt  <= w_cntNext;
        end
    end

    // Capture FSM with registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_digits <= '0;
            r_valid  <= '0;
            r_update <= 1'b0;
            r_updIdx <= '0;
            r_error  <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_error  <= 1'b0;

            if (!w_active) begin
                r_state <= IDLE;
            end else if (w_accept) begin
                r_state <= HOLD;
            end else if ((r_state == HOLD) && !w_changed) begin
                r_state <= HOLD;
            end else begin
                r_state <= COUNT;
            end

            // Clear first; an acceptance below overrides its own bit.
            if (Clear) begin
                r_valid <= '0;
            end

            if (w_accept) begin
                if (!w_oneHot) begin
                    r_error <= 1'b1;
                end else if (w_legal) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_sel[i]) begin
                            r_digits[4*i +: 4] <= w_value;
                            r_valid[i]         <= 1'b1;
                        end
                    end
                    r_update <= 1'b1;
                    r_updIdx <= w_idx;
                end else begin
                    // Blank or unknown glyph: value kept, validity dropped
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_sel[i]) begin
                            r_valid[i] <= 1'b0;
                        end
                    end
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign Digits     = r_digits;
    assign DigitValid = r_valid;
    assign Update     = r_update;
    assign UpdIdx     = r_updIdx;
    assign Error      = r_error;

endmodule : seven_seg_capture_decoder
`default_nettype wire
